// File: rtl/ltc2308_emu_if.sv
// Pin-level interface between an LTC2308 controller and the emulated converter.
// The controller is the master; the emulated device is the slave.
interface ltc2308_emu_if;
  logic ADC_CONVST;
  logic ADC_SCK;
  logic ADC_SDI;
  logic ADC_SDO;

  modport master (
    output ADC_CONVST,
    output ADC_SCK,
    output ADC_SDI,
    input  ADC_SDO
  );

  modport slave (
    input  ADC_CONVST,
    input  ADC_SCK,
    input  ADC_SDI,
    output ADC_SDO
  );
endinterface

// File: rtl/ltc2308_emu.sv
// Clock-oversampled LTC2308 device-side emulation returning fabric-supplied channel values.
// Optional LTC2308_EMU_BUSY_CHECK_EN enables the sticky proto_err protocol checker.
module ltc2308_emu #(
  parameter int unsigned CONV_CYCLES = 80,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  ltc2308_emu_if.slave        bus,
  input  logic [95:0]         chan_value,
  output logic [5:0]          cfg_word,
  output logic                cfg_update,
  output logic                conv_done,
  output logic                busy,
  output logic                proto_err
);

  localparam int unsigned CntW = $clog2(CONV_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StConv, StWait, StShift} state_e;

  logic [SYNC_STAGES-1:0] r_convst_sync, r_sck_sync, r_sdi_sync;
  logic                   r_convst_dly, r_sck_dly;
  logic                   w_convst, w_sck, w_sdi;
  logic                   w_convst_rise, w_sck_rise, w_sck_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_convst_sync <= '0;
      r_sck_sync    <= '0;
      r_sdi_sync    <= '0;
      r_convst_dly  <= 1'b0;
      r_sck_dly     <= 1'b0;
    end else begin
      r_convst_sync <= {r_convst_sync[SYNC_STAGES-2:0], bus.ADC_CONVST};
      r_sck_sync    <= {r_sck_sync[SYNC_STAGES-2:0], bus.ADC_SCK};
      r_sdi_sync    <= {r_sdi_sync[SYNC_STAGES-2:0], bus.ADC_SDI};
      r_convst_dly  <= w_convst;
      r_sck_dly     <= w_sck;
    end
  end

  assign w_convst      = r_convst_sync[SYNC_STAGES-1];
  assign w_sck         = r_sck_sync[SYNC_STAGES-1];
  assign w_sdi         = r_sdi_sync[SYNC_STAGES-1];
  assign w_convst_rise = w_convst & ~r_convst_dly;
  assign w_sck_rise    = w_sck & ~r_sck_dly;
  assign w_sck_fall    = ~w_sck & r_sck_dly;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [11:0]     r_result, w_result_nxt;
  logic [3:0]      r_bitcnt, w_bitcnt_nxt;
  logic [5:0]      r_cfg_sh, w_cfg_sh_nxt;
  logic [2:0]      r_cfg_n, w_cfg_n_nxt;
  logic [5:0]      r_cfg_word, w_cfg_word_nxt;
  logic            r_cfg_update, w_cfg_update_nxt;
  logic            r_conv_done, w_conv_done_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_sdo, w_sdo_nxt;
  logic            w_start, w_commit;

  logic [11:0] w_chans [8];
  for (genvar g = 0; g < 8; g++) begin : g_chan
    assign w_chans[g] = chan_value[12*g +: 12];
  end

  // A CONVST abort from SHIFT with a full config converts with that fresh config.
  logic [5:0]  w_conv_cfg;
  logic [2:0]  w_ch;
  logic [11:0] w_snapshot;
  assign w_conv_cfg = ((r_state == StShift) && (r_cfg_n == 3'd6)) ? r_cfg_sh : r_cfg_word;
  assign w_ch       = {w_conv_cfg[3], w_conv_cfg[2], w_conv_cfg[4]};
  assign w_snapshot = w_chans[w_ch] ^ {~w_conv_cfg[1], 11'b0};

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_result_nxt     = r_result;
    w_bitcnt_nxt     = r_bitcnt;
    w_cfg_sh_nxt     = r_cfg_sh;
    w_cfg_n_nxt      = r_cfg_n;
    w_cfg_word_nxt   = r_cfg_word;
    w_cfg_update_nxt = 1'b0;
    w_conv_done_nxt  = 1'b0;
    w_busy_nxt       = r_busy;
    w_sdo_nxt        = r_sdo;
    w_start          = 1'b0;
    w_commit         = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_sdo_nxt = 1'b0;
        w_start   = w_convst_rise;
      end
      StConv: begin
        if (r_cnt <= CntW'(1)) begin
          w_cnt_nxt       = '0;
          w_busy_nxt      = 1'b0;
          w_conv_done_nxt = 1'b1;
          w_state_nxt     = StWait;
        end else begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end
      StWait: begin
        if (w_convst_rise) begin
          w_start = 1'b1;
        end else if (!w_convst) begin
          w_sdo_nxt    = r_result[11];
          w_bitcnt_nxt = '0;
          w_cfg_n_nxt  = '0;
          w_state_nxt  = StShift;
        end
      end
      StShift: begin
        if (w_convst_rise) begin
          w_commit = (r_cfg_n == 3'd6);
          w_start  = 1'b1;
        end else begin
          if (w_sck_rise && (r_cfg_n != 3'd6)) begin
            w_cfg_sh_nxt = {r_cfg_sh[4:0], w_sdi};
            w_cfg_n_nxt  = r_cfg_n + 3'd1;
          end
          if (w_sck_fall) begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd11) begin
              w_sdo_nxt   = 1'b0;
              w_commit    = (r_cfg_n == 3'd6);
              w_state_nxt = StIdle;
            end else begin
              w_sdo_nxt = r_result[4'd10 - r_bitcnt];
            end
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_start) begin
      w_result_nxt = w_snapshot;
      w_cnt_nxt    = CntW'(CONV_CYCLES);
      w_busy_nxt   = 1'b1;
      w_sdo_nxt    = 1'b0;
      w_state_nxt  = StConv;
    end
    if (w_commit) begin
      w_cfg_word_nxt   = r_cfg_sh;
      w_cfg_update_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_result     <= '0;
      r_bitcnt     <= '0;
      r_cfg_sh     <= '0;
      r_cfg_n      <= '0;
      r_cfg_word   <= 6'b100010;
      r_cfg_update <= 1'b0;
      r_conv_done  <= 1'b0;
      r_busy       <= 1'b0;
      r_sdo        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_result     <= w_result_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_cfg_sh     <= w_cfg_sh_nxt;
      r_cfg_n      <= w_cfg_n_nxt;
      r_cfg_word   <= w_cfg_word_nxt;
      r_cfg_update <= w_cfg_update_nxt;
      r_conv_done  <= w_conv_done_nxt;
      r_busy       <= w_busy_nxt;
      r_sdo        <= w_sdo_nxt;
    end
  end

  assign bus.ADC_SDO = r_sdo;
  assign cfg_word    = r_cfg_word;
  assign cfg_update  = r_cfg_update;
  assign conv_done   = r_conv_done;
  assign busy        = r_busy;

`ifdef LTC2308_EMU_BUSY_CHECK_EN
  logic r_proto_err;
  logic w_proto_evt;
  assign w_proto_evt = ((r_state == StConv) && (w_sck_rise || w_sck_fall || w_convst_rise)) ||
                       ((r_state == StShift) && w_convst_rise);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= r_proto_err | w_proto_evt;
    end
  end
  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

endmodule
